// File: rtl/pll_rst_pkg.sv
// Shared types and sizing helpers for the PLL reset supervisor.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        RST_ASSERT = 2'd0,
        WAIT_LOCK  = 2'd1,
        STABLE     = 2'd2,
        RUN        = 2'd3
    } pll_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic int cnt_width(
        input int a,
        input int b,
        input int c
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    function automatic int retry_width(input int max_retry);
        return $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL power-up and lock-loss supervisor: pulses PLL reset, waits
// for stable lock, then releases the downstream system reset.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    output logic                  pll_reset,
    output logic                  sys_rst_n,
    output logic                  pll_ready,
    output logic                  pll_fail,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CW = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC,
                                  LOCK_STABLE_CYC);
    localparam int RW = retry_width(MAX_RETRY);

    localparam logic [CW-1:0] C_PULSE_END = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] C_TMO_END   = CW'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that first sees lock is stable cycle one.
    localparam logic [CW-1:0] C_STB_END   = CW'(LOCK_STABLE_CYC - 2);

    localparam logic [RW-1:0] C_RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [RW-1:0] C_RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [LOSS_CNT_W-1:0] C_LOSS_SAT = '1;

    logic                  w_lock_s;
    pll_state_e            r_state;
    pll_state_e            w_next;
    logic [CW-1:0]         r_cnt;
    logic [RW-1:0]         r_retry;
    logic [LOSS_CNT_W-1:0] r_loss;
    logic                  r_fail;
    logic                  r_pll_reset;
    logic                  r_sys_rst_n;
    logic                  r_ready;

    logic w_pulse_done;
    logic w_timeout;
    logic w_stable_done;
    logic w_lock_lost;
    logic w_pll_reset;
    logic w_run;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    always_comb begin
        w_pulse_done  = (r_state == RST_ASSERT) &&
                        (r_cnt == C_PULSE_END);
        w_timeout     = (r_state == WAIT_LOCK) && !w_lock_s &&
                        (r_cnt == C_TMO_END);
        w_stable_done = (r_state == STABLE) && w_lock_s &&
                        (r_cnt == C_STB_END);
        w_lock_lost   = (r_state == RUN) && !w_lock_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_ASSERT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RST_ASSERT: begin
                if (w_pulse_done) w_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lock_s)       w_next = STABLE;
                else if (w_timeout) w_next = RST_ASSERT;
            end
            STABLE: begin
                if (!w_lock_s)          w_next = WAIT_LOCK;
                else if (w_stable_done) w_next = RUN;
            end
            RUN: begin
                if (w_lock_lost) w_next = RST_ASSERT;
            end
            default: w_next = RST_ASSERT;
        endcase
    end

    always_comb begin
        w_pll_reset = (w_next == RST_ASSERT);
        w_run       = (w_next == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_pll_reset <= w_pll_reset;
            r_sys_rst_n <= w_run;
            r_ready     <= w_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state != RUN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry <= '0;
            r_fail  <= 1'b0;
        end else begin
            if (w_stable_done) begin
                r_retry <= '0;
            end else if (w_timeout && (r_retry != C_RETRY_MAX)) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_timeout && (r_retry >= C_RETRY_LAST)) begin
                r_fail <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss <= '0;
        end else if (w_lock_lost && (r_loss != C_LOSS_SAT)) begin
            r_loss <= r_loss + 1'b1;
        end
    end

    assign pll_reset     = r_pll_reset;
    assign sys_rst_n     = r_sys_rst_n;
    assign pll_ready     = r_ready;
    assign pll_fail      = r_fail;
    assign lock_loss_cnt = r_loss;

endmodule
